// File: rtl/rr_arbiter_6_if.sv
// Request/grant bundle between six bus requesters and rr_arbiter_6.
// master = requester side, slave = arbiter side.
interface rr_arbiter_6_if;
  logic [5:0] req;
  logic [5:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output preempt
  );
endinterface

// File: rtl/rr_arbiter_6.sv
// Six-way round-robin bus arbiter with registered grant and mux select.
// Define ARB_HOLD_LIMIT_EN to force hand-over after MAX_HOLD cycles.
module rr_arbiter_6 #(
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_6_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;
  localparam logic [2:0] NONE  = 3'b111;

  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..15");
  end

  logic [0:0] state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] sel_q, sel_n;
  logic [5:0] gnt_q, gnt_n;
  logic       busy_q;
  logic       own_req;
  logic [5:0] others;
  logic [2:0] win_all;
  logic [2:0] win_oth;
  logic       take;
  logic [2:0] w;

  // Lowest rotation offset from p wins; 3'b111 means no request.
  function automatic logic [2:0] pick(
    input logic [5:0] r,
    input logic [2:0] p
  );
    logic [2:0] res;
    int         j;
    res = NONE;
    for (int k = 5; k >= 0; k--) begin
      j = (int'(p) + k) % 6;
      if (r[j]) res = 3'(j);
    end
    return res;
  endfunction

  assign own_req = |(bus.req & gnt_q);
  assign others  = bus.req & ~gnt_q;
  assign win_all = pick(bus.req, ptr);
  assign win_oth = pick(others, ptr);

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [3:0] HMAX = 4'(MAX_HOLD - 1);

  logic [3:0] hcnt, hcnt_n;
  logic       pre_q, pre_n;
  logic       expire;

  assign expire = (hcnt == HMAX) && (|others);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_q;
    gnt_n   = gnt_q;
    hcnt_n  = hcnt;
    pre_n   = 1'b0;
    take    = 1'b0;
    w       = win_all;
    unique case (1'b1)
      (state == IDLE): begin
        take = |bus.req;
      end
      (own_req && expire): begin
        take  = 1'b1;
        w     = win_oth;
        pre_n = 1'b1;
      end
      own_req: begin
        if (hcnt != HMAX) hcnt_n = hcnt + 4'd1;
      end
      default: begin
        take = |bus.req;
      end
    endcase
    if (take) begin
      state_n = OWNED;
      sel_n   = w;
      gnt_n   = 6'd1 << w;
      ptr_n   = (w == 3'd5) ? 3'd0 : w + 3'd1;
      hcnt_n  = 4'd0;
    end else if (!own_req) begin
      state_n = IDLE;
      sel_n   = NONE;
      gnt_n   = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt  <= 4'd0;
      pre_q <= 1'b0;
    end else begin
      hcnt  <= hcnt_n;
      pre_q <= pre_n;
    end
  end

  assign bus.preempt = pre_q;
`else
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_q;
    gnt_n   = gnt_q;
    take    = 1'b0;
    w       = win_all;
    unique case (1'b1)
      (state == IDLE): take = |bus.req;
      own_req:         take = 1'b0;
      default:         take = |bus.req;
    endcase
    if (take) begin
      state_n = OWNED;
      sel_n   = w;
      gnt_n   = 6'd1 << w;
      ptr_n   = (w == 3'd5) ? 3'd0 : w + 3'd1;
    end else if (!own_req) begin
      state_n = IDLE;
      sel_n   = NONE;
      gnt_n   = 6'd0;
    end
  end

  assign bus.preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      sel_q  <= NONE;
      gnt_q  <= 6'd0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      sel_q  <= sel_n;
      gnt_q  <= gnt_n;
      busy_q <= |gnt_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_rr_arbiter_6.sv
// Directed bench for rr_arbiter_6: vector table plus hold-limit runs.
// Expectations follow ARB_HOLD_LIMIT_EN when it is defined.
module tb_rr_arbiter_6;

  typedef struct {
    logic       rst_n;
    logic [5:0] req;
    logic [5:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       pre;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  rr_arbiter_6_if bus ();

  rr_arbiter_6 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      name,
    input logic [5:0] eg,
    input logic [2:0] es,
    input logic       eb,
    input logic       ep
  );
    tests++;
    if (bus.gnt !== eg || bus.sel !== es ||
        bus.busy !== eb || bus.preempt !== ep) begin
      fails++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b pre=%b, exp gnt=%b sel=%0d busy=%b pre=%b",
               name, bus.gnt, bus.sel, bus.busy, bus.preempt,
               eg, es, eb, ep);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] q);
    rst_n   = r;
    bus.req = q;
    @(posedge clk);
    #1;
  endtask

  vec_t v[$];

  task automatic add(
    input logic r, input logic [5:0] q,
    input logic [5:0] g, input logic [2:0] s,
    input logic b, input logic p
  );
    vec_t t;
    t.rst_n = r; t.req = q; t.gnt = g;
    t.sel = s; t.busy = b; t.pre = p;
    v.push_back(t);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = 6'd0;
    // reset, first grant, hand-over, idle
    add(0, 6'b000000, 6'b000000, 3'd7, 0, 0);
    add(1, 6'b100100, 6'b000100, 3'd2, 1, 0);
    add(1, 6'b100100, 6'b000100, 3'd2, 1, 0);
    add(1, 6'b100000, 6'b100000, 3'd5, 1, 0);
    add(1, 6'b000000, 6'b000000, 3'd7, 0, 0);
    // full rotation from ptr=0
    add(0, 6'b000000, 6'b000000, 3'd7, 0, 0);
    add(1, 6'b111111, 6'b000001, 3'd0, 1, 0);
    add(1, 6'b111110, 6'b000010, 3'd1, 1, 0);
    add(1, 6'b111101, 6'b000100, 3'd2, 1, 0);
    add(1, 6'b111011, 6'b001000, 3'd3, 1, 0);
    add(1, 6'b110111, 6'b010000, 3'd4, 1, 0);
    add(1, 6'b101111, 6'b100000, 3'd5, 1, 0);
    add(1, 6'b011111, 6'b000001, 3'd0, 1, 0);
    // reset while owner 4 holds
    add(0, 6'b000000, 6'b000000, 3'd7, 0, 0);
    add(1, 6'b010000, 6'b010000, 3'd4, 1, 0);
    add(0, 6'b010000, 6'b000000, 3'd7, 0, 0);
    add(1, 6'b010000, 6'b010000, 3'd4, 1, 0);
    // reset restores ptr=0: 0 beats 4
    add(0, 6'b010001, 6'b000000, 3'd7, 0, 0);
    add(1, 6'b010001, 6'b000001, 3'd0, 1, 0);
    add(1, 6'b010000, 6'b010000, 3'd4, 1, 0);
    // release and re-request gets no priority
    add(1, 6'b000011, 6'b000001, 3'd0, 1, 0);
    add(1, 6'b000010, 6'b000010, 3'd1, 1, 0);

    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rst_n, v[i].req);
      check($sformatf("vec%0d", i), v[i].gnt, v[i].sel,
            v[i].busy, v[i].pre);
    end

    // req[1] and req[3] held from reset
    step(0, 6'b000000);
    check("hold_rst", 6'b0, 3'd7, 0, 0);
    begin
      int         own;
      int         cnt;
      logic       pre;
      own = 1;
      cnt = 0;
      for (int c = 0; c < 100; c++) begin
        step(1, 6'b001010);
        pre = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        if (c > 0) begin
          if (cnt == 3) begin
            own = (own == 1) ? 3 : 1;
            cnt = 0;
            pre = 1'b1;
          end else begin
            cnt++;
          end
        end
`endif
        check($sformatf("hold13_c%0d", c), 6'(1 << own),
              3'(own), 1, pre);
      end
    end

    // only req[1]: never preempted
    step(0, 6'b000000);
    for (int c = 0; c < 30; c++) begin
      step(1, 6'b000010);
      check($sformatf("hold1_c%0d", c), 6'b000010, 3'd1, 1, 0);
    end
    step(1, 6'b000000);
    check("hold1_release", 6'b0, 3'd7, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
